// File: rtl/sd_block_reader_if.sv
// Byte-engine handshake plus sector-buffer write port shared by the SD block reader.
// master = block reader side, slave = byte engine / buffer side.
interface sd_block_reader_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 9;

  logic              start;
  logic [BYTE_W-1:0] in;
  logic              ready;
  logic [BYTE_W-1:0] into;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [BYTE_W-1:0] wr_data;

  modport master (
    output start, in, wr_en, wr_addr, wr_data,
    input  ready, into
  );

  modport slave (
    input  start, in, wr_en, wr_addr, wr_data,
    output ready, into
  );
endinterface

// File: rtl/sd_block_reader.sv
// Reads one SD data block through the SPI byte engine: start-token hunt,
// data capture into the sector buffer, and CRC16-CCITT (XMODEM) check.
module sd_block_reader #(
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned TOKEN_TRIES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  sd_block_reader_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               err_code
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned TRY_W  = 8;
  localparam int unsigned CRC_W  = 16;

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(BLOCK_BYTES - 1);
  localparam logic [TRY_W-1:0]  LAST_TRY    = TRY_W'(TOKEN_TRIES - 1);
  localparam logic [BYTE_W-1:0] FILL_BYTE   = 8'hFF;
  localparam logic [BYTE_W-1:0] START_TOKEN = 8'hFE;
  localparam logic [CRC_W-1:0]  CRC_POLY    = 16'h1021;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_TOKEN   = 2'd2;
  localparam logic [1:0] ERR_CRC     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOKEN,
    S_DATA,
    S_CRC_HI,
    S_CRC_LO,
    S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [BYTE_W-1:0]   rx_hi_q, rx_hi_d;
  logic                pending_q, pending_d;
  logic                start_q, start_d;
  logic [BYTE_W-1:0]   in_q, in_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [1:0]          err_q, err_d;
  logic                take_c;

  // Byte-wide CRC16 update, MSB first, no reflection.
  function automatic logic [CRC_W-1:0] crc16_upd(input logic [CRC_W-1:0] crc,
                                                 input logic [BYTE_W-1:0] data);
    logic [CRC_W-1:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[CRC_W-1] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  // A ready only counts when it answers our own outstanding request.
  assign take_c = bus.ready & pending_q;

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    rx_hi_d   = rx_hi_q;
    pending_d = pending_q & ~take_c;
    start_d   = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_TOKEN;
          tries_d = '0;
          idx_d   = '0;
          crc_d   = '0;
          err_d   = ERR_OK;
          busy_d  = 1'b1;
          start_d = 1'b1;
        end
      end
      S_TOKEN: begin
        if (take_c) begin
          if (bus.into == START_TOKEN) begin
            state_d = S_DATA;
            start_d = 1'b1;
          end else if (bus.into[7:4] == 4'h0 && bus.into != 8'h00) begin
            state_d = S_FIN;
            err_d   = ERR_TOKEN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (tries_q == LAST_TRY) begin
            state_d = S_FIN;
            err_d   = ERR_TIMEOUT;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            tries_d = tries_q + TRY_W'(1);
            start_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (take_c) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = bus.into;
          crc_d     = crc16_upd(crc_q, bus.into);
          start_d   = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_CRC_HI;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      S_CRC_HI: begin
        if (take_c) begin
          rx_hi_d = bus.into;
          state_d = S_CRC_LO;
          start_d = 1'b1;
        end
      end
      S_CRC_LO: begin
        if (take_c) begin
          state_d = S_FIN;
          err_d   = (crc_q == {rx_hi_q, bus.into}) ? ERR_OK : ERR_CRC;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pending_d = pending_d | start_d;
    in_d      = start_d ? FILL_BYTE : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tries_q   <= '0;
      idx_q     <= '0;
      crc_q     <= '0;
      rx_hi_q   <= '0;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      in_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_OK;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      idx_q     <= idx_d;
      crc_q     <= crc_d;
      rx_hi_q   <= rx_hi_d;
      pending_q <= pending_d;
      start_q   <= start_d;
      in_q      <= in_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.start   = start_q;
  assign bus.in      = in_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_code    = err_q;
endmodule

// File: tb/tb_sd_block_reader.sv
// Two readers (512/256 and 9/8) share one modelled byte engine over an OR bus;
// a scoreboard compares buffer writes and completion codes against a block-level model.
module tb_sd_block_reader;
  localparam int unsigned BB_A = 512;
  localparam int unsigned TT_A = 256;
  localparam int unsigned BB_B = 9;
  localparam int unsigned TT_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic       go_a = 1'b0, go_b = 1'b0;
  logic       busy_a, done_a, busy_b, done_b;
  logic [1:0] err_a, err_b;

  sd_block_reader_if ifa ();
  sd_block_reader_if ifb ();

  sd_block_reader #(.BLOCK_BYTES(BB_A), .TOKEN_TRIES(TT_A)) dut_a (
    .clk(clk), .rst(rst_a), .go(go_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .err_code(err_a)
  );

  sd_block_reader #(.BLOCK_BYTES(BB_B), .TOKEN_TRIES(TT_B)) dut_b (
    .clk(clk), .rst(rst_b), .go(go_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .err_code(err_b)
  );

  logic       eng_ready = 1'b0;
  logic [7:0] eng_into  = 8'h00;
  logic       start_any;
  logic [7:0] in_any;

  assign ifa.ready = eng_ready;
  assign ifb.ready = eng_ready;
  assign ifa.into  = eng_into;
  assign ifb.into  = eng_into;
  assign start_any = ifa.start | ifb.start;
  assign in_any    = ifa.in | ifb.in;

  int n_pass = 0, n_check = 0, n_start = 0, wr_cnt_a = 0, wr_cnt_b = 0;
  bit spur = 1'b0;
  logic [7:0]  rsp_q[$];
  logic [7:0]  blk[$];
  logic [16:0] exp_wr_a[$], exp_wr_b[$];
  int          exp_done_a[$], exp_done_b[$];

  task automatic check(input bit ok, input string nm, input int act, input int exp);
    n_check++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference CRC-16/XMODEM, one message bit at a time.
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic bit busy_of(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction

  function automatic bit done_of(input int w);
    return (w == 0) ? done_a : done_b;
  endfunction

  task automatic set_go(input int w, input bit v);
    if (w == 0) go_a = v;
    else go_b = v;
  endtask

  // Byte engine: answers each start after 1..3 cycles with the next queued byte (0xFF when empty).
  initial begin : engine
    int cd;
    cd = 0;
    forever begin
      @(negedge clk);
      eng_ready = 1'b0;
      eng_into  = 8'h00;
      check(in_any == (start_any ? 8'hFF : 8'h00), "in_byte", int'(in_any),
            int'(start_any ? 8'hFF : 8'h00));
      if (start_any) begin
        n_start++;
        check(cd == 0, "single_outstanding", cd, 0);
        cd = int'($urandom_range(1, 3));
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          eng_ready = 1'b1;
          eng_into  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'hFF;
        end
      end else if (spur) begin
        eng_ready = 1'b1;
        eng_into  = 8'hFE;
        spur      = 1'b0;
      end
    end
  end

  // Scoreboard monitor: pops expected writes and completion codes as the DUTs present them.
  initial begin : monitor
    logic [16:0] e;
    int d;
    forever begin
      @(negedge clk);
      if (ifa.wr_en) begin
        wr_cnt_a++;
        check(exp_wr_a.size() != 0, "a_wr_expected", int'({ifa.wr_addr, ifa.wr_data}), -1);
        if (exp_wr_a.size() != 0) begin
          e = exp_wr_a.pop_front();
          check({ifa.wr_addr, ifa.wr_data} == e, "a_wr_addr_data",
                int'({ifa.wr_addr, ifa.wr_data}), int'(e));
        end
      end
      if (ifb.wr_en) begin
        wr_cnt_b++;
        check(exp_wr_b.size() != 0, "b_wr_expected", int'({ifb.wr_addr, ifb.wr_data}), -1);
        if (exp_wr_b.size() != 0) begin
          e = exp_wr_b.pop_front();
          check({ifb.wr_addr, ifb.wr_data} == e, "b_wr_addr_data",
                int'({ifb.wr_addr, ifb.wr_data}), int'(e));
        end
      end
      if (done_a) begin
        check(exp_done_a.size() != 0, "a_done_expected", int'(err_a), -1);
        if (exp_done_a.size() != 0) begin
          d = exp_done_a.pop_front();
          check(int'(err_a) == d, "a_err_code", int'(err_a), d);
        end
        check(!busy_a, "a_busy_at_done", int'(busy_a), 0);
      end
      if (done_b) begin
        check(exp_done_b.size() != 0, "b_done_expected", int'(err_b), -1);
        if (exp_done_b.size() != 0) begin
          d = exp_done_b.pop_front();
          check(int'(err_b) == d, "b_err_code", int'(err_b), d);
        end
        check(!busy_b, "b_busy_at_done", int'(busy_b), 0);
      end
    end
  end

  task automatic check_zero(input int w, input string nm);
    if (w == 0)
      check({ifa.start, ifa.in, ifa.wr_en, ifa.wr_addr, ifa.wr_data, busy_a, done_a, err_a} == '0,
            nm, int'({ifa.start, ifa.in, ifa.wr_en, ifa.wr_addr, ifa.wr_data, busy_a, done_a, err_a}), 0);
    else
      check({ifb.start, ifb.in, ifb.wr_en, ifb.wr_addr, ifb.wr_data, busy_b, done_b, err_b} == '0,
            nm, int'({ifb.start, ifb.in, ifb.wr_en, ifb.wr_addr, ifb.wr_data, busy_b, done_b, err_b}), 0);
  endtask

  // Model the whole block from the byte stream, queue expectations, then run it.
  task automatic run_block(input int which, input logic [7:0] rsp[$], input int force_err,
                           input bit abuse);
    int bb, tt, pos, err, s0, cyc, lim;
    bit found, got;
    logic [7:0]  b;
    logic [15:0] crc, rx;
    bb = (which == 0) ? int'(BB_A) : int'(BB_B);
    tt = (which == 0) ? int'(TT_A) : int'(TT_B);
    pos = 0; err = 1; found = 1'b0;
    for (int t = 0; t < tt; t++) begin
      b = (pos < rsp.size()) ? rsp[pos] : 8'hFF;
      pos++;
      if (b == 8'hFE) begin found = 1'b1; break; end
      if (b[7:4] == 4'h0 && b != 8'h00) begin err = 2; break; end
    end
    if (found) begin
      crc = 16'h0000;
      for (int k = 0; k < bb; k++) begin
        b = (pos < rsp.size()) ? rsp[pos] : 8'hFF;
        pos++;
        if (which == 0) exp_wr_a.push_back({9'(k), b});
        else exp_wr_b.push_back({9'(k), b});
        crc = crc_ref(crc, b);
      end
      rx[15:8] = (pos < rsp.size()) ? rsp[pos] : 8'hFF;
      rx[7:0]  = (pos + 1 < rsp.size()) ? rsp[pos + 1] : 8'hFF;
      pos += 2;
      err = (crc == rx) ? 0 : 3;
    end
    if (force_err >= 0) err = force_err;
    if (which == 0) exp_done_a.push_back(err);
    else exp_done_b.push_back(err);

    rsp_q = rsp;
    s0 = n_start;
    set_go(which, 1'b1);
    @(negedge clk);
    set_go(which, 1'b0);
    check(busy_of(which), "busy_after_go", int'(busy_of(which)), 1);
    got = 1'b0; cyc = 0; lim = (tt + bb + 2) * 5 + 20;
    while (!got && cyc < lim) begin
      @(negedge clk);
      cyc++;
      set_go(which, abuse && (cyc % 37) == 5);
      if (done_of(which)) got = 1'b1;
    end
    check(got, "done_timeout", int'(got), 1);
    set_go(which, abuse);
    @(negedge clk);
    set_go(which, 1'b0);
    check(n_start - s0 == pos, "start_count", n_start - s0, pos);
    check(((which == 0) ? exp_wr_a.size() : exp_wr_b.size()) == 0, "writes_missing",
          (which == 0) ? exp_wr_a.size() : exp_wr_b.size(), 0);
    if (abuse) begin
      repeat (4) @(negedge clk);
      check(!busy_of(which), "go_at_done_ignored", int'(busy_of(which)), 0);
      check(n_start - s0 == pos, "no_start_after_done", n_start - s0, pos);
    end
    rsp_q.delete();
  endtask

  task automatic rand_block(input int bb, input int nlead, input bit bad_tok, input bit bad_crc);
    logic [15:0] c;
    logic [7:0]  d;
    blk.delete();
    c = 16'h0000;
    for (int i = 0; i < nlead; i++) begin
      case ($urandom_range(0, 3))
        0:       blk.push_back(8'h00);
        1:       blk.push_back(8'hA5);
        default: blk.push_back(8'hFF);
      endcase
    end
    if (bad_tok) blk.push_back(8'($urandom_range(1, 15)));
    else blk.push_back(8'hFE);
    for (int k = 0; k < bb; k++) begin
      d = 8'($urandom);
      blk.push_back(d);
      c = crc_ref(c, d);
    end
    if (bad_crc) c = c ^ 16'(1 << $urandom_range(0, 15));
    blk.push_back(c[15:8]);
    blk.push_back(c[7:0]);
  endtask

  task automatic reset_mid();
    int w0, s0, lim;
    rand_block(BB_A, 1, 1'b0, 1'b0);
    for (int k = 0; k < int'(BB_A); k++) exp_wr_a.push_back({9'(k), blk[k + 2]});
    rsp_q = blk;
    w0 = wr_cnt_a;
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    lim = 0;
    while (wr_cnt_a - w0 < 100 && lim < 2000) begin
      @(negedge clk);
      lim++;
    end
    check(wr_cnt_a - w0 >= 100, "reset_wait_writes", wr_cnt_a - w0, 100);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    exp_wr_a.delete();
    check_zero(0, "reset_mid_outputs");
    s0 = n_start;
    w0 = wr_cnt_a;
    repeat (12) @(negedge clk);
    check(n_start == s0, "start_after_reset", n_start - s0, 0);
    check(wr_cnt_a == w0, "wr_after_reset", wr_cnt_a - w0, 0);
    rsp_q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    check_zero(0, "reset_a");
    check_zero(1, "reset_b");
    @(negedge clk);

    // Normal 512-byte block of zeros behind three fillers.
    blk.delete();
    repeat (3) blk.push_back(8'hFF);
    blk.push_back(8'hFE);
    repeat (BB_A + 2) blk.push_back(8'h00);
    run_block(0, blk, 0, 1'b0);

    // Known CRC vector "123456789" -> 0x31C3, then a corrupted low byte.
    blk.delete();
    blk.push_back(8'hFE);
    for (int i = 0; i < 9; i++) blk.push_back(8'(8'h31 + i));
    blk.push_back(8'h31);
    blk.push_back(8'hC3);
    run_block(1, blk, 0, 1'b0);
    blk[11] = 8'hC4;
    run_block(1, blk, 3, 1'b0);

    // Token timeout: engine only ever returns 0xFF.
    blk.delete();
    run_block(1, blk, 1, 1'b0);

    // Data-error token, then a clean block on both readers.
    blk.delete();
    blk.push_back(8'hFF);
    blk.push_back(8'h05);
    run_block(1, blk, 2, 1'b0);
    rand_block(BB_B, 2, 1'b0, 1'b0);
    run_block(1, blk, 0, 1'b0);
    blk.delete();
    blk.push_back(8'hFF);
    blk.push_back(8'h05);
    run_block(0, blk, 2, 1'b0);

    // Reset in the middle of the data phase, then a fresh block from address 0.
    reset_mid();
    rand_block(BB_A, 2, 1'b0, 1'b0);
    run_block(0, blk, 0, 1'b0);

    // Spurious ready while idle, then go pulses during busy and at done.
    spur = 1'b1;
    repeat (4) @(negedge clk);
    rand_block(BB_A, 3, 1'b0, 1'b0);
    run_block(0, blk, 0, 1'b1);

    // Randomized short blocks: fillers, zero bytes, error tokens, timeouts, CRC faults.
    for (int it = 0; it < 24; it++) begin
      rand_block(BB_B, int'($urandom_range(0, 9)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0));
      run_block(1, blk, -1, ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end
endmodule

// File: doc/sd_block_reader.md
Name: sd_block_reader

Overview:
- Receives one SD data block over the SPI byte engine after the command path has issued CMD17 and got R1.
- Clocks 0xFF filler bytes out, hunts for the 0xFE start token, then captures BLOCK_BYTES data bytes into the sector buffer.
- Reads the 2-byte CRC16 and checks it against a locally computed CRC16-CCITT.
- Sits beside the command sender and shares the byte engine's start/in/ready/into handshake. Its start/in outputs are ORed with the other requesters.

Parameters:
- BLOCK_BYTES, 512, number of data bytes per block. Legal range is 1..512.
- TOKEN_TRIES, 256, maximum filler bytes to issue while waiting for the start token. Legal range is 1..256.

Ports:
- clk  in  1  system clock, same clock as the SPI byte engine.
- rst  in  1  synchronous, active-high reset.
- go  in  1  one-cycle request to read one block. Ignored while busy=1.
- start  out  1  one-cycle pulse asking the byte engine to shift out in[7:0].
- in  out  8  byte to transmit. 0xFF while start=1, 0x00 otherwise (OR-bus safe).
- ready  in  1  one-cycle pulse from the byte engine. into[7:0] is valid in that cycle.
- into  in  8  byte received by the byte engine.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  9  buffer byte address.
- wr_data  out  8  buffer write data.
- busy  out  1  high from the cycle after go until the cycle done pulses.
- done  out  1  one-cycle completion pulse (success or failure).
- err_code  out  2  result code, valid from done until the next accepted go. 0 = ok, 1 = token timeout, 2 = data-error token, 3 = CRC mismatch.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, crc register 0x0000. Reset takes effect at the next clk edge from any state. No start or wr_en is issued after that edge, and a partially filled buffer is simply abandoned.
- States are IDLE, TOKEN, DATA, CRC_HI, CRC_LO, FIN.
- Byte request rule: on entering TOKEN, DATA, CRC_HI or CRC_LO (and on re-arming within TOKEN/DATA), start=1 with in=0xFF for exactly one cycle.
- After that pulse the block waits for ready. A ready seen with no request outstanding is ignored.
- There is at most one outstanding request.
- The next request's start is issued in the cycle after the ready that completed the previous byte.
- IDLE: go=1 leads to TOKEN. Same edge: try counter cleared, byte index cleared, crc cleared to 0x0000, err_code cleared to 0, busy set.
- TOKEN, on ready:
  - into==0xFE: go to DATA.
  - into[7:4]==4'h0 and into!=0x00: data-error token. Go to FIN with err_code=2.
  - Otherwise, if tries==TOKEN_TRIES-1: go to FIN with err_code=1.
  - Otherwise: tries+1 and re-request.
  - Total filler bytes on timeout is exactly TOKEN_TRIES.
- DATA, on ready:
  - Next cycle: wr_en=1 for one cycle, wr_addr=index, wr_data=into (all registered).
  - crc is updated with into, MSB-first, poly 0x1021.
  - If index==BLOCK_BYTES-1, go to CRC_HI; else index+1 and re-request.
  - wr_addr counts 0..BLOCK_BYTES-1 and never wraps.
- CRC_HI, on ready: latch into as rx_crc[15:8], go to CRC_LO.
- CRC_LO, on ready: latch into as rx_crc[7:0]. Go to FIN with err_code = (crc=={rx_crc[15:8],into}) ? 0 : 3.
- FIN: done=1 for one cycle, busy=0 in that same cycle, then IDLE.
  - A go coinciding with done is ignored.
  - A go in the first IDLE cycle is accepted.
- CRC arithmetic: 16-bit, no reflection, no final XOR. It covers data bytes only, never the token or CRC bytes.
- The last data byte's wr_en occurs in the same cycle as the CRC_HI start.
- Worst-case latency from go to done is 1 + (TOKEN_TRIES + BLOCK_BYTES + 2) byte times + 1 cycle.

Test Plan:
- Normal block: engine returns FF, FF, FF, FE, then 512×0x00, then 00 00.
  - Expect 4 token requests, 512 wr_en pulses with addr 0..511 and data 0x00.
  - Expect 514 further starts, done with err_code=0, busy low afterwards.
- CRC value check, BLOCK_BYTES=9: token FE, data "123456789" (0x31..0x39), CRC bytes 31 C3.
  - Expect err_code=0.
  - Repeat with CRC bytes 31 C4: expect err_code=3, and all 9 writes still performed.
- Token timeout, TOKEN_TRIES=8: engine always returns 0xFF.
  - Expect exactly 8 start pulses, zero wr_en, done with err_code=1.
- Data-error token: engine returns FF then 0x05.
  - Expect done with err_code=2 after the 2nd byte, zero wr_en.
  - A following go succeeds normally.
- Reset mid-transfer: assert rst for 1 cycle after the 100th data write.
  - Expect all outputs 0 from the next edge, no further start/wr_en.
  - A new go restarts at wr_addr 0.
- Protocol abuse: go pulsed while busy, and a spurious ready in IDLE.
  - Expect both ignored: transfer count, addresses and err_code unchanged vs the normal run.
